// File: rtl/wb_commit_queue.sv
// In-order writeback commit buffer: two results in per cycle, two register file writes out per cycle.
// Optional WB_QUEUE_FWD_EN adds four combinational forwarding lookup ports.
module wb_commit_queue #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 32,
   parameter int AW     = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid_1,
   input  logic [AW-1:0]             in_rd_1,
   input  logic [DATA_W-1:0]         in_data_1,
   input  logic                      in_valid_2,
   input  logic [AW-1:0]             in_rd_2,
   input  logic [DATA_W-1:0]         in_data_2,
   output logic                      in_ready,
   input  logic                      wb_stall,
   output logic                      reg_write_1,
   output logic [AW-1:0]             rd_1,
   output logic [DATA_W-1:0]         rd_data_1,
   output logic                      reg_write_2,
   output logic [AW-1:0]             rd_2,
   output logic [DATA_W-1:0]         rd_data_2,
   output logic [$clog2(DEPTH):0]    count
`ifdef WB_QUEUE_FWD_EN
   ,
   input  logic [AW-1:0]             fwd_rs_1,
   input  logic [AW-1:0]             fwd_rs_2,
   input  logic [AW-1:0]             fwd_rs_3,
   input  logic [AW-1:0]             fwd_rs_4,
   output logic                      fwd_hit_1,
   output logic                      fwd_hit_2,
   output logic                      fwd_hit_3,
   output logic                      fwd_hit_4,
   output logic [DATA_W-1:0]         fwd_data_1,
   output logic [DATA_W-1:0]         fwd_data_2,
   output logic [DATA_W-1:0]         fwd_data_3,
   output logic [DATA_W-1:0]         fwd_data_4
`endif
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]     head_q, head_d, tail_q, tail_d, head_p1;
   logic [CW-1:0]     count_q, count_d;
   logic [AW-1:0]     mem_rd_q   [DEPTH];
   logic [DATA_W-1:0] mem_data_q [DEPTH];
   logic              q1, q2;
   logic [1:0]        push, pop;
   logic              reg_write_1_q, reg_write_2_q;
   logic [AW-1:0]     rd_1_q, rd_2_q;
   logic [DATA_W-1:0] rd_data_1_q, rd_data_2_q;

   // Readiness uses the registered count only, so a same-cycle pop gives no credit.
   assign in_ready = (count_q <= CW'(DEPTH - 2));
   assign q1       = in_valid_1 && in_ready && (in_rd_1 != '0);
   assign q2       = in_valid_2 && in_ready && (in_rd_2 != '0);
   assign push     = {1'b0, q1} + {1'b0, q2};
   assign pop      = wb_stall ? 2'd0 : (count_q >= CW'(2)) ? 2'd2 : count_q[1:0];
   assign head_p1  = head_q + PW'(1);
   assign head_d   = head_q + PW'(pop);
   assign tail_d   = tail_q + PW'(push);
   assign count_d  = count_q + CW'(push) - CW'(pop);

   // Storage needs no reset: only slots covered by count are ever read.
   always_ff @(posedge clk) begin
      if (q1) begin
         mem_rd_q[tail_q]   <= in_rd_1;
         mem_data_q[tail_q] <= in_data_1;
      end
      if (q2) begin
         mem_rd_q[tail_q + PW'(q1)]   <= in_rd_2;
         mem_data_q[tail_q + PW'(q1)] <= in_data_2;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         reg_write_1_q <= 1'b0;
         reg_write_2_q <= 1'b0;
         rd_1_q        <= '0;
         rd_2_q        <= '0;
         rd_data_1_q   <= '0;
         rd_data_2_q   <= '0;
      end else begin
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         reg_write_1_q <= (pop >= 2'd1);
         reg_write_2_q <= (pop == 2'd2);
         if (pop >= 2'd1) begin
            rd_1_q      <= mem_rd_q[head_q];
            rd_data_1_q <= mem_data_q[head_q];
         end
         if (pop == 2'd2) begin
            rd_2_q      <= mem_rd_q[head_p1];
            rd_data_2_q <= mem_data_q[head_p1];
         end
      end
   end

   assign reg_write_1 = reg_write_1_q;
   assign reg_write_2 = reg_write_2_q;
   assign rd_1        = rd_1_q;
   assign rd_2        = rd_2_q;
   assign rd_data_1   = rd_data_1_q;
   assign rd_data_2   = rd_data_2_q;
   assign count       = count_q;

`ifdef WB_QUEUE_FWD_EN
   logic [3:0][AW-1:0]     fwd_rs;
   logic [3:0]             fwd_hit;
   logic [3:0][DATA_W-1:0] fwd_dat;

   assign fwd_rs = {fwd_rs_4, fwd_rs_3, fwd_rs_2, fwd_rs_1};
   assign {fwd_hit_4, fwd_hit_3, fwd_hit_2, fwd_hit_1} = fwd_hit;
   assign fwd_data_1 = fwd_dat[0];
   assign fwd_data_2 = fwd_dat[1];
   assign fwd_data_3 = fwd_dat[2];
   assign fwd_data_4 = fwd_dat[3];

   // Scan oldest to youngest so the last match wins; output registers are oldest.
   always_comb begin
      fwd_hit = '0;
      fwd_dat = '0;
      for (int k = 0; k < 4; k++) begin
         if (reg_write_1_q && rd_1_q == fwd_rs[k]) begin
            fwd_hit[k] = 1'b1;
            fwd_dat[k] = rd_data_1_q;
         end
         if (reg_write_2_q && rd_2_q == fwd_rs[k]) begin
            fwd_hit[k] = 1'b1;
            fwd_dat[k] = rd_data_2_q;
         end
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count_q && mem_rd_q[head_q + PW'(i)] == fwd_rs[k]) begin
               fwd_hit[k] = 1'b1;
               fwd_dat[k] = mem_data_q[head_q + PW'(i)];
            end
         end
         if (fwd_rs[k] == '0) fwd_hit[k] = 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Randomized bench for wb_commit_queue against a queue-based reference model.
module tb_wb_commit_queue;
   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid_1, in_valid_2, wb_stall;
   logic [4:0]  in_rd_1, in_rd_2;
   logic [31:0] in_data_1, in_data_2;
   logic        in_ready, reg_write_1, reg_write_2;
   logic [4:0]  rd_1, rd_2;
   logic [31:0] rd_data_1, rd_data_2;
   logic [3:0]  count;
`ifdef WB_QUEUE_FWD_EN
   logic [4:0]  fwd_rs = '0;
   logic        fh1, fh2, fh3, fh4;
   logic [31:0] fd1, fd2, fd3, fd4;
`endif

   wb_commit_queue #(.DEPTH(DEPTH), .DATA_W(32), .AW(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid_1(in_valid_1), .in_rd_1(in_rd_1), .in_data_1(in_data_1),
      .in_valid_2(in_valid_2), .in_rd_2(in_rd_2), .in_data_2(in_data_2),
      .in_ready(in_ready), .wb_stall(wb_stall),
      .reg_write_1(reg_write_1), .rd_1(rd_1), .rd_data_1(rd_data_1),
      .reg_write_2(reg_write_2), .rd_2(rd_2), .rd_data_2(rd_data_2),
      .count(count)
`ifdef WB_QUEUE_FWD_EN
      , .fwd_rs_1(fwd_rs), .fwd_rs_2(fwd_rs), .fwd_rs_3(fwd_rs), .fwd_rs_4(fwd_rs),
      .fwd_hit_1(fh1), .fwd_hit_2(fh2), .fwd_hit_3(fh3), .fwd_hit_4(fh4),
      .fwd_data_1(fd1), .fwd_data_2(fd2), .fwd_data_3(fd3), .fwd_data_4(fd4)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] d;
   } ent_t;

   ent_t        mq[$];
   logic        e_rw1, e_rw2;
   logic [4:0]  e_rd1, e_rd2;
   logic [31:0] e_d1, e_d2;
   logic [31:0] rf [32];
   int          ncheck = 0, nfail = 0;
   bit          chk_en = 1'b0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      ncheck++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      e_rw1 = 1'b0; e_rw2 = 1'b0;
      e_rd1 = '0; e_rd2 = '0; e_d1 = '0; e_d2 = '0;
   endtask

   // Drive one cycle of inputs, then advance the model across the edge.
   task automatic step(input bit v1, input logic [4:0] r1, input logic [31:0] d1,
                       input bit v2, input logic [4:0] r2, input logic [31:0] d2, input bit st);
      int   n;
      bit   rdy;
      ent_t e;
      in_valid_1 = v1; in_rd_1 = r1; in_data_1 = d1;
      in_valid_2 = v2; in_rd_2 = r2; in_data_2 = d2;
      wb_stall   = st;
      @(posedge clk);
      rdy   = (mq.size() <= DEPTH - 2);
      n     = st ? 0 : ((mq.size() >= 2) ? 2 : mq.size());
      e_rw1 = (n >= 1);
      e_rw2 = (n == 2);
      if (n >= 1) begin e = mq.pop_front(); e_rd1 = e.rd; e_d1 = e.d; end
      if (n == 2) begin e = mq.pop_front(); e_rd2 = e.rd; e_d2 = e.d; end
      if (rdy && v1 && r1 != 0) mq.push_back('{rd: r1, d: d1});
      if (rdy && v2 && r2 != 0) mq.push_back('{rd: r2, d: d2});
      #1;
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Reset is asserted between edges; outputs must clear without a clock.
   task automatic do_reset();
      chk_en = 1'b0;
      in_valid_1 = 0; in_valid_2 = 0; wb_stall = 0;
      rst = 1'b1;
      #1;
      model_reset();
      check("rst_count", count, 0);
      check("rst_rw1", reg_write_1, 0);
      check("rst_rw2", reg_write_2, 0);
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);
      rst    = 1'b0;
      chk_en = 1'b1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("count", count, 64'(mq.size()));
         check("in_ready", in_ready, 64'(mq.size() <= DEPTH - 2));
         check("reg_write_1", reg_write_1, e_rw1);
         check("reg_write_2", reg_write_2, e_rw2);
         check("rd_1", rd_1, e_rd1);
         check("rd_data_1", rd_data_1, e_d1);
         check("rd_2", rd_2, e_rd2);
         check("rd_data_2", rd_data_2, e_d2);
         if (reg_write_1) rf[rd_1] = rd_data_1;
         if (reg_write_2) rf[rd_2] = rd_data_2;
      end
   end

   initial begin
      for (int i = 0; i < 32; i++) rf[i] = '0;
      in_rd_1 = 0; in_rd_2 = 0; in_data_1 = 0; in_data_2 = 0;
      #2;
      do_reset();

      // single lane 1 write
      step(1, 3, 32'h11, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("t1_rw1", reg_write_1, 1);
      check("t1_rd1", rd_1, 3);
      check("t1_data1", rd_data_1, 32'h11);
      check("t1_rw2", reg_write_2, 0);

      // same rd in both lanes: port 2 carries the younger value
      step(1, 5, 32'hA, 1, 5, 32'hB, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      check("t2_data1", rd_data_1, 32'hA);
      check("t2_data2", rd_data_2, 32'hB);
      idle(1);
      check("t2_rf5", rf[5], 32'hB);

      // fill under stall, extra pair ignored, then drain
      for (int p = 0; p < 4; p++)
         step(1, 5'(2 * p + 1), 32'h100 + 32'(p), 1, 5'(2 * p + 2), 32'h200 + 32'(p), 1);
      check("t3_full_ready", in_ready, 0);
      check("t3_full_count", count, 8);
      step(1, 9, 32'hDEAD, 1, 10, 32'hBEEF, 1);
      check("t3_ignored_count", count, 8);
      idle(4);
      check("t3_drained", count, 0);

      // r0 on lane 1 is dropped, lane 2 compacts to port 1
      step(1, 0, 32'h55, 1, 7, 32'h77, 0);
      check("t4_count", count, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      check("t4_rw1", reg_write_1, 1);
      check("t4_rd1", rd_1, 7);
      check("t4_data1", rd_data_1, 32'h77);
      check("t4_rw2", reg_write_2, 0);
      idle(1);

      // wrap: tail at 7 after seven singles, first pair straddles 7 -> 0
      do_reset();
      for (int s = 0; s < 7; s++) step(1, 5'(s + 1), 32'h300 + 32'(s), 0, 0, 0, 1);
      idle(4);
      for (int p = 0; p < 3; p++)
         step(1, 5'(p + 11), 32'h400 + 32'(p), 1, 5'(p + 21), 32'h500 + 32'(p), 1);
      step(0, 0, 0, 0, 0, 0, 0);
      check("t5_wrap_rd1", rd_1, 11);
      check("t5_wrap_rd2", rd_2, 21);
      idle(3);

      // random traffic
      for (int c = 0; c < 500; c++)
         step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
              $urandom_range(0, 3) == 0);
      idle(5);

      // reset in the middle of a drain
      for (int p = 0; p < 3; p++) step(1, 5'(p + 1), 32'h600 + 32'(p), 1, 5'(p + 4), 32'h700 + 32'(p), 1);
      step(1, 9, 32'h799, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      check("t6_pre_count", count, 5);
      do_reset();
      step(1, 12, 32'hC0DE, 0, 0, 0, 0);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", ncheck, nfail);
      $finish;
   end
endmodule

// File: doc/wb_commit_queue.md
Name: wb_commit_queue

Overview:
- In-order writeback commit buffer for the two-issue core.
- Accepts up to two results per cycle from the execute/memory pipes and buffers them in a circular FIFO.
- Drains up to two results per cycle, in program order, into the register file's two write ports (reg_write_1/2, rd_1/2, rd_data_1/2).
- Port 2 is always the younger write, so the register file's rule of port 2 winning on equal rd gives correct last-writer semantics.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 4.
- DATA_W, 32, result data width.
- AW, 5, register index width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid_1  in  1  lane 1 result valid; lane 1 is the older instruction.
- in_rd_1  in  AW  lane 1 destination register.
- in_data_1  in  DATA_W  lane 1 result.
- in_valid_2  in  1  lane 2 result valid; lane 2 is the younger instruction.
- in_rd_2  in  AW  lane 2 destination register.
- in_data_2  in  DATA_W  lane 2 result.
- in_ready  out  1  both lanes may be presented this cycle.
- wb_stall  in  1  suppress draining this cycle.
- reg_write_1  out  1  register file write enable, port 1 (older).
- rd_1  out  AW  port 1 destination.
- rd_data_1  out  DATA_W  port 1 data.
- reg_write_2  out  1  register file write enable, port 2 (younger).
- rd_2  out  AW  port 2 destination.
- rd_data_2  out  DATA_W  port 2 data.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset: asynchronous clear of head, tail, count, reg_write_1, reg_write_2, rd_1, rd_2, rd_data_1, rd_data_2. in_ready evaluates to 1 after reset. Reset mid-drain discards all pending entries.
- in_ready = (count <= DEPTH-2).
  - Computed from the registered count only; a pop in the same cycle gives no credit.
- Enqueue filter: a lane is enqueued when in_valid_x && in_ready && in_rd_x != 0. Writes to r0 are dropped at enqueue and never occupy a slot.
- Compaction:
  - If only lane 2 qualifies, it takes the single tail slot.
  - If both qualify, lane 1 goes to tail and lane 2 to tail+1.
  - push is 0, 1 or 2; tail advances by push modulo DEPTH.
- Valid while not ready: the input is ignored and not stored. The upstream pipe must hold its data.
- Drain:
  - When !wb_stall, pop = min(count, 2).
  - Head goes to port 1 and head+1 to port 2; head advances by pop modulo DEPTH.
- Output registers, updated every edge:
  - reg_write_1 <= (pop >= 1); reg_write_2 <= (pop == 2).
  - rd_x and rd_data_x load only when the corresponding port is written, otherwise they hold.
  - When count == 1, only port 1 fires.
- Latency: an entry enqueued at edge N is popped at edge N+1 at the earliest. Its reg_write is high from edge N+1 to N+2, so the register file commits it at edge N+2.
- Stall: while wb_stall = 1, reg_write_1 and reg_write_2 are 0 on the following cycle and entries are retained.
- Occupancy: count_next = count + push - pop in the same cycle. Never exceeds DEPTH; never underflows.
- Order: strict FIFO. Lane 1 is always older than lane 2 of the same cycle.
- Wrap-around: head and tail wrap modulo DEPTH, including the case where a 2-entry push straddles index DEPTH-1 → 0.

Optional Feature:
- Macro: WB_QUEUE_FWD_EN.
- Defined: adds ports fwd_rs_1/fwd_rs_2/fwd_rs_3/fwd_rs_4 (in, AW), fwd_hit_1..4 (out, 1) and fwd_data_1..4 (out, DATA_W).
  - Combinational search of valid FIFO entries plus the output-register entries currently asserting reg_write.
  - Returns the youngest match; output registers are the oldest.
  - Hit on rs==0 is forced to 0.
- Undefined: those ports and the search logic are absent.

Test Plan:
- Reset, then lane 1 = (rd=3, 0x11) with lane 2 invalid → reg_write_1 = 1, rd_1 = 3, rd_data_1 = 0x11 two edges later; reg_write_2 = 0.
- Both lanes (rd=5, 0xA) and (rd=5, 0xB) same cycle → same output cycle: port 1 = (5, 0xA), port 2 = (5, 0xB); the register file ends with r5 = 0xB.
- wb_stall = 1, push 4 pairs (8 entries) into DEPTH=8 → in_ready low once count = 7 or 8; extra valid pair is ignored. Release stall → 4 drain cycles, FIFO order preserved.
- Lane 1 rd=0, lane 2 (rd=7, 0x77) → count increments by 1; only port 1 fires with (7, 0x77).
- Wrap-around: push 7 singles, drain, push 3 pairs → outputs match the push order across index 7→0.
- Assert rst mid-drain with count = 5 → count = 0, reg_write_1 = reg_write_2 = 0 immediately without a clock edge; in_ready = 1.
